// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: default widths,
// FSM state encoding and requester port indices.
// Configuration macro used by this slice: DMEM_ARB_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DM_ADDRESS_DEF = 9;
    localparam int DATA_W_DEF     = 32;

    // Requester indices into req_i / we_i / gnt_o / done_o
    localparam int P_CORE   = 0;
    localparam int P_LOADER = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational arbitration decision between the two data-memory requesters.
// Ports:
//   req_i  [1:0] in   request vector (bit 0 = core, bit 1 = loader)
//   prio_i       in   index of the port that wins a contention
//   win_o  [1:0] out  one-hot winner (all-zero when nobody requests)
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = req_i;
        if (req_i == 2'b11) begin
            win_o           = 2'b00;
            win_o[P_CORE]   = ~prio_i;
            win_o[P_LOADER] = prio_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory. Each transaction
// runs IDLE -> ACCESS -> DONE -> IDLE; requests are only sampled in IDLE.
// Policy: fixed priority to port 0 by default; define DMEM_ARB_ROUND_ROBIN_EN
// to alternate contended grants with a 1-bit last-grant register.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_i, we_i [1:0]     per-requester request / write-enable
//   addr0_i, addr1_i      per-requester word address
//   wdata0_i, wdata1_i    per-requester write data
//   gnt_o  [1:0]          one-hot grant, high during ACCESS
//   done_o [1:0]          one-hot completion, high during DONE
//   rdata_o               registered read data, valid with done_o on a read
//   busy_o                high whenever not IDLE
//   MemRead, MemWrite     memory strobes (ACCESS only)
//   a, wd                 memory address / write data
//   rd                    combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [DM_ADDRESS-1:0] addr0_i,
    input  logic [DM_ADDRESS-1:0] addr1_i,
    input  logic [DATA_W-1:0]     wdata0_i,
    input  logic [DATA_W-1:0]     wdata1_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  busy_o,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd
);

    state_t                state_q, state_d;
    logic [1:0]            win_q;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;

    logic [1:0]            win;
    logic                  win_idx;
    logic                  prio;
    logic                  take;

    // A new transaction is accepted only from IDLE
    assign take    = (state_q == S_IDLE) && (req_i != 2'b00);
    assign win_idx = win[P_LOADER];

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Contended grant goes to the port that was not granted last. Reset value
    // pretends the loader was last so that port 0 is favoured first.
    assign prio = ~last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= win_idx;
        end
    end
`else
    assign prio = 1'b0;
`endif

    dmem_arb_pick u_pick (
        .req_i  (req_i),
        .prio_i (prio),
        .win_o  (win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner's transaction so the requester is free to change its
    // inputs once granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                win_q   <= win;
                we_q    <= we_i[win_idx];
                addr_q  <= win_idx ? addr1_i  : addr0_i;
                wdata_q <= win_idx ? wdata1_i : wdata0_i;
            end
            if ((state_q == S_ACCESS) && !we_q) begin
                rdata_q <= rd;
            end
        end
    end

    // Strobes decode from the state register, so an asynchronous reset in
    // ACCESS removes MemWrite before the next edge can commit a write.
    always_comb begin
        state_d  = state_q;
        gnt_o    = 2'b00;
        done_o   = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                gnt_o    = win_q;
                MemWrite = we_q;
                MemRead  = ~we_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_o  = win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign a       = addr_q;
    assign wd      = wdata_q;
    assign rdata_o = rdata_q;

endmodule
